// File: rtl/spi_slave_tx_if.sv
`timescale 1ns/1ps
// Pin and handshake bundle of the SPI MISO transmitter.
// The slave modport is the transmitter; the master modport is the SPI master plus the frame source.
interface spi_slave_tx_if #(
    parameter int FRAME_WIDTH = 24
);
    logic                   sclk;
    logic                   cs;
    logic                   miso;
    logic [FRAME_WIDTH-1:0] i_tx_frame;
    logic                   i_tx_load;
    logic                   o_tx_ready;
    logic                   o_tx_busy;
    logic                   o_tx_done;
    logic                   o_tx_abort;
    logic                   o_tx_underrun;

    modport slave (
        input  sclk,
        input  cs,
        input  i_tx_frame,
        input  i_tx_load,
        output miso,
        output o_tx_ready,
        output o_tx_busy,
        output o_tx_done,
        output o_tx_abort,
        output o_tx_underrun
    );

    modport master (
        output sclk,
        output cs,
        output i_tx_frame,
        output i_tx_load,
        input  miso,
        input  o_tx_ready,
        input  o_tx_busy,
        input  o_tx_done,
        input  o_tx_abort,
        input  o_tx_underrun
    );
endinterface

// File: rtl/spi_slave_tx.sv
`timescale 1ns/1ps
// SPI mode-0 MISO transmitter: one MSB-first status frame per chip-select window, sysclk domain.
// Optional macro MISO_TRISTATE_EN releases miso (1'bz) while idle or in reset.
module spi_slave_tx #(
    parameter int                     FRAME_WIDTH = 24,
    parameter logic [FRAME_WIDTH-1:0] IDLE_FILL   = '0,
    parameter int                     SYNC_STAGES = 2
) (
    input  logic          sysclk,
    input  logic          rst,
    spi_slave_tx_if.slave bus
);
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = $clog2(FRAME_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Synchronizer chains: indices 0..SYNC_N-1 sync, index SYNC_N is the edge-history flop.
    logic [SYNC_N:0] sclk_pipe_q, sclk_pipe_d;
    logic [SYNC_N:0] cs_pipe_q, cs_pipe_d;

    for (genvar gi = 0; gi <= SYNC_N; gi++) begin : g_sync
        if (gi == 0) begin : g_head
            assign sclk_pipe_d[gi] = bus.sclk;
            assign cs_pipe_d[gi]   = bus.cs;
        end else begin : g_tail
            assign sclk_pipe_d[gi] = sclk_pipe_q[gi-1];
            assign cs_pipe_d[gi]   = cs_pipe_q[gi-1];
        end
    end

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;

    assign sclk_rise =  sclk_pipe_q[SYNC_N-1] & ~sclk_pipe_q[SYNC_N];
    assign cs_fall   = ~cs_pipe_q[SYNC_N-1]   &  cs_pipe_q[SYNC_N];
    assign cs_rise   =  cs_pipe_q[SYNC_N-1]   & ~cs_pipe_q[SYNC_N];

    state_t                 state_q, state_d;
    logic [FRAME_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   miso_q, miso_d;
    logic [FRAME_WIDTH-1:0] pend_q, pend_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic                   underrun_q, underrun_d;
    logic                   load_ok;
    logic [FRAME_WIDTH-1:0] tx_frame;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sclk_pipe_q  <= '0;
            cs_pipe_q    <= '1;
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            miso_q       <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            sclk_pipe_q  <= sclk_pipe_d;
            cs_pipe_q    <= cs_pipe_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            miso_q       <= miso_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        miso_d       = miso_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;
        underrun_d   = 1'b0;
        tx_frame     = IDLE_FILL;
        load_ok      = bus.i_tx_load & ~pend_valid_q;

        if (load_ok) begin
            pend_d       = bus.i_tx_frame;
            pend_valid_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                cnt_d  = '0;
                if (cs_fall) begin
                    // A load landing on the cs-fall cycle bypasses the empty buffer.
                    if (pend_valid_q) begin
                        tx_frame     = pend_q;
                        pend_valid_d = 1'b0;
                    end else if (load_ok) begin
                        tx_frame     = bus.i_tx_frame;
                        pend_valid_d = 1'b0;
                    end else begin
                        underrun_d   = 1'b1;
                    end
                    shift_d = tx_frame;
                    miso_d  = tx_frame[FRAME_WIDTH-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    miso_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    // The master has just sampled miso, so the next bit can be launched.
                    cnt_d   = cnt_q + 1'b1;
                    shift_d = {shift_q[FRAME_WIDTH-2:0], 1'b0};
                    if (cnt_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        miso_d  = 1'b0;
                        state_d = HOLD;
                    end else begin
                        miso_d  = shift_q[FRAME_WIDTH-2];
                    end
                end
            end
            HOLD: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                miso_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_tx_ready    = ~pend_valid_q;
    assign bus.o_tx_busy     = (state_q != IDLE);
    assign bus.o_tx_done     = done_q;
    assign bus.o_tx_abort    = abort_q;
    assign bus.o_tx_underrun = underrun_q;

`ifdef MISO_TRISTATE_EN
    assign bus.miso = (rst || state_q == IDLE) ? 1'bz : miso_q;
`else
    assign bus.miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_tx.sv
`timescale 1ns/1ps
// Testbench for spi_slave_tx: behavioural SPI master at ~26 MHz sclk against a 125 MHz sysclk,
// with a frame scoreboard fed by the load/cs-fall model.
module tb_spi_slave_tx;
    localparam int            FW   = 24;
    localparam int            SYNC = 2;
    localparam logic [FW-1:0] FILL = 24'h000000;
`ifdef MISO_TRISTATE_EN
    localparam logic MISO_OFF = 1'bz;
`else
    localparam logic MISO_OFF = 1'b0;
`endif

    logic sysclk = 1'b0;
    logic rst;
    always #4 sysclk = ~sysclk;

    spi_slave_tx_if #(.FRAME_WIDTH(FW)) bus ();

    spi_slave_tx #(
        .FRAME_WIDTH(FW),
        .IDLE_FILL  (FILL),
        .SYNC_STAGES(SYNC)
    ) dut (
        .sysclk(sysclk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    logic [FW-1:0] exp_q[$];
    bit            mdl_full = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            done_cnt = 0;
    int            abort_cnt = 0;
    int            urun_cnt = 0;

    always @(negedge sysclk) begin
        if (bus.o_tx_done === 1'b1)     done_cnt  <= done_cnt + 1;
        if (bus.o_tx_abort === 1'b1)    abort_cnt <= abort_cnt + 1;
        if (bus.o_tx_underrun === 1'b1) urun_cnt  <= urun_cnt + 1;
    end

    // Frame-source side: a load is accepted only while the model buffer is empty.
    task automatic load_frame(input logic [FW-1:0] f);
        @(negedge sysclk);
        bus.i_tx_frame = f;
        bus.i_tx_load  = 1'b1;
        @(negedge sysclk);
        bus.i_tx_load  = 1'b0;
        if (!mdl_full) begin
            exp_q.push_back(f);
            mdl_full = 1'b1;
        end
        $display("load   frame=%06h accepted_by_model=%0b", f, mdl_full);
    endtask

    task automatic cs_low();
        @(negedge sysclk);
        #1.7;
        bus.cs = 1'b0;
        if (!mdl_full) exp_q.push_back(FILL);
        mdl_full = 1'b0;
        repeat (6) @(negedge sysclk);
    endtask

    task automatic cs_high();
        #5.3;
        bus.cs = 1'b1;
        repeat (6) @(negedge sysclk);
    endtask

    // Edges fall at 1ns + k*19.2ns after a negedge, so never on a sysclk posedge.
    task automatic shift_bits(input int n, output logic [FW-1:0] cap);
        cap = '0;
        @(negedge sysclk);
        #1.0;
        for (int i = 0; i < n; i++) begin
            cap = {cap[FW-2:0], bus.miso};
            bus.sclk = 1'b1;
            #19.2;
            bus.sclk = 1'b0;
            #19.2;
        end
    endtask

    task automatic check_frame(input string name, input logic [FW-1:0] cap);
        logic [FW-1:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: captured %06h but scoreboard empty", name, cap);
        end else begin
            e = exp_q.pop_front();
            if (cap !== e) begin
                n_bad++;
                $display("FAIL %s: captured %06h expected %06h", name, cap, e);
            end else begin
                $display("frame  %s captured=%06h", name, cap);
            end
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.cs         = 1'b1;
        bus.sclk       = 1'b0;
        bus.i_tx_load  = 1'b0;
        bus.i_tx_frame = '0;
        repeat (4) @(negedge sysclk);
        rst = 1'b0;
        repeat (2) @(negedge sysclk);
        n_cmp++; if (bus.o_tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.o_tx_ready); end
        n_cmp++; if (bus.o_tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.o_tx_busy); end
        n_cmp++; if (bus.miso !== MISO_OFF) begin n_bad++; $display("FAIL reset_miso: got %b want %b", bus.miso, MISO_OFF); end
        n_cmp++; if ({bus.o_tx_done, bus.o_tx_abort, bus.o_tx_underrun} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 000", {bus.o_tx_done, bus.o_tx_abort, bus.o_tx_underrun});
        end
        $display("reset  ready=%b busy=%b miso=%b", bus.o_tx_ready, bus.o_tx_busy, bus.miso);
    endtask

    task automatic test_basic();
        logic [FW-1:0] cap;
        logic [FW-1:0] junk;
        int d0 = done_cnt;
        int u0 = urun_cnt;
        load_frame(24'hA5037E);
        n_cmp++; if (bus.o_tx_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_after_load: got %b want 0", bus.o_tx_ready); end
        cs_low();
        n_cmp++; if (bus.o_tx_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_shift: got %b want 1", bus.o_tx_busy); end
        shift_bits(FW, cap);
        repeat (4) @(negedge sysclk);
        check_frame("basic", cap);
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (bus.o_tx_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_hold: got %b want 1", bus.o_tx_busy); end
        shift_bits(2, junk);
        repeat (4) @(negedge sysclk);
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL basic_extra_sclk_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (bus.miso !== 1'b0) begin n_bad++; $display("FAIL basic_hold_miso: got %b want 0", bus.miso); end
        cs_high();
        n_cmp++; if (bus.o_tx_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b want 0", bus.o_tx_busy); end
        n_cmp++; if (bus.o_tx_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_end: got %b want 1", bus.o_tx_ready); end
        n_cmp++; if (urun_cnt != u0) begin n_bad++; $display("FAIL basic_no_underrun: got %0d want 0", urun_cnt - u0); end
    endtask

    task automatic test_underrun();
        logic [FW-1:0] cap;
        int d0 = done_cnt;
        int u0 = urun_cnt;
        cs_low();
        shift_bits(FW, cap);
        repeat (4) @(negedge sysclk);
        cs_high();
        check_frame("underrun", cap);
        n_cmp++; if (urun_cnt - u0 != 1) begin n_bad++; $display("FAIL underrun_count: got %0d want 1", urun_cnt - u0); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL underrun_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_double_load();
        logic [FW-1:0] cap;
        load_frame(24'h111111);
        load_frame(24'h222222);
        n_cmp++; if (bus.o_tx_ready !== 1'b0) begin n_bad++; $display("FAIL dbl_ready: got %b want 0", bus.o_tx_ready); end
        cs_low();
        shift_bits(FW, cap);
        cs_high();
        check_frame("dbl_first", cap);
        load_frame(24'h222222);
        cs_low();
        shift_bits(FW, cap);
        cs_high();
        check_frame("dbl_second", cap);
    endtask

    task automatic test_abort();
        logic [FW-1:0] cap;
        logic [FW-1:0] e;
        int d0 = done_cnt;
        int a0 = abort_cnt;
        load_frame(24'h333CC3);
        cs_low();
        n_cmp++; if (bus.o_tx_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready_in_shift: got %b want 1", bus.o_tx_ready); end
        load_frame(24'h5A5A5A);
        shift_bits(10, cap);
        cs_high();
        n_cmp++; if (abort_cnt - a0 != 1) begin n_bad++; $display("FAIL abort_count: got %0d want 1", abort_cnt - a0); end
        n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
        n_cmp++; if (bus.o_tx_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.o_tx_busy); end
        n_cmp++; if (bus.o_tx_ready !== 1'b0) begin n_bad++; $display("FAIL abort_pending_kept: got %b want 0", bus.o_tx_ready); end
        e = exp_q.pop_front();
        n_cmp++; if (cap[9:0] !== e[FW-1 -: 10]) begin
            n_bad++; $display("FAIL abort_partial: got %03h want %03h", cap[9:0], e[FW-1 -: 10]);
        end
        $display("abort  partial=%03h", cap[9:0]);
        cs_low();
        shift_bits(FW, cap);
        cs_high();
        check_frame("after_abort", cap);
    endtask

    task automatic test_bypass();
        logic [FW-1:0] cap;
        int u0 = urun_cnt;
        @(negedge sysclk);
        bus.cs = 1'b0;
        repeat (SYNC) @(negedge sysclk);
        bus.i_tx_frame = 24'hB17E42;
        bus.i_tx_load  = 1'b1;
        @(negedge sysclk);
        bus.i_tx_load  = 1'b0;
        exp_q.push_back(24'hB17E42);
        n_cmp++; if (bus.o_tx_ready !== 1'b1) begin n_bad++; $display("FAIL bypass_ready: got %b want 1", bus.o_tx_ready); end
        n_cmp++; if (bus.o_tx_busy !== 1'b1) begin n_bad++; $display("FAIL bypass_busy: got %b want 1", bus.o_tx_busy); end
        repeat (4) @(negedge sysclk);
        shift_bits(FW, cap);
        cs_high();
        check_frame("bypass", cap);
        n_cmp++; if (urun_cnt != u0) begin n_bad++; $display("FAIL bypass_underrun: got %0d want 0", urun_cnt - u0); end
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] cap;
        logic [FW-1:0] e;
        int d0 = done_cnt;
        int a0 = abort_cnt;
        load_frame(24'hC0FFEE);
        cs_low();
        load_frame(24'h0F0F0F);
        shift_bits(8, cap);
        e = exp_q.pop_front();
        n_cmp++; if (cap[7:0] !== e[FW-1 -: 8]) begin n_bad++; $display("FAIL rstmid_partial: got %02h want %02h", cap[7:0], e[FW-1 -: 8]); end
        @(negedge sysclk);
        rst = 1'b1;
        @(negedge sysclk);
        n_cmp++; if (bus.miso !== MISO_OFF) begin n_bad++; $display("FAIL rstmid_miso: got %b want %b", bus.miso, MISO_OFF); end
        n_cmp++; if (bus.o_tx_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", bus.o_tx_ready); end
        n_cmp++; if (bus.o_tx_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", bus.o_tx_busy); end
        bus.cs = 1'b1;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        repeat (6) @(negedge sysclk);
        exp_q.delete();
        mdl_full = 1'b0;
        n_cmp++; if (done_cnt != d0 || abort_cnt != a0) begin
            n_bad++; $display("FAIL rstmid_pulses: done %0d abort %0d want 0 0", done_cnt - d0, abort_cnt - a0);
        end
        $display("rstmid ready=%b busy=%b miso=%b", bus.o_tx_ready, bus.o_tx_busy, bus.miso);
        // Pending frame was dropped by reset, so an empty window must underrun.
        cs_low();
        shift_bits(FW, cap);
        cs_high();
        check_frame("after_reset", cap);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_double_load();
        test_abort();
        test_bypass();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drained: %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
